// File: rtl/snn_pkg.sv
// snn_pkg
// Shared definitions for the spiking-network blocks: the rate-decoder
// control state encoding, the 8-bit saturation ceiling and a helper that
// clamps a 9-bit sum into 8 bits.
package snn_pkg;

  // Control FSM states for the rate decoder
  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } ctrl_state_t;

  // Ceiling for every 8-bit saturating quantity (spike counts, trace)
  localparam logic [7:0] SAT_MAX = 8'd255;

  // Clamp a 9-bit sum to SAT_MAX
  function automatic logic [7:0] sat8(input logic [8:0] sum);
    return (sum > {1'b0, SAT_MAX}) ? SAT_MAX : sum[7:0];
  endfunction

endpackage

// File: rtl/syn_trace.sv
// syn_trace
// Standalone exponentially decaying synapse. Every cycle the trace halves
// and, if a spike arrives, WEIGHT is added; the sum saturates at 255.
// Ports:
//   clk   - clock, all state updates on the rising edge
//   rst   - synchronous active-high reset, clears the trace
//   spike - incoming spike, sampled every cycle
//   trace - 8-bit decaying synaptic current
module syn_trace
  import snn_pkg::*;
#(
  parameter logic [7:0] WEIGHT = 8'd50
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       spike,
  output logic [7:0] trace
);

  logic [8:0] trace_sum;

  // The 9-bit sum cannot overflow: 127 + 255 fits, so a single clamp suffices
  always_comb begin
    trace_sum = {2'b00, trace[7:1]} + {1'b0, (spike ? WEIGHT : 8'd0)};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      trace <= '0;
    end else begin
      trace <= sat8(trace_sum);
    end
  end

endmodule

// File: rtl/spike_rate_decoder.sv
// spike_rate_decoder
// Counts spikes over fixed windows of WINDOW cycles while enabled and
// offers each completed count through a valid/ready handshake. A result
// that completes while the previous one is still pending is dropped and
// flagged on the sticky overrun output. A decaying synaptic trace of the
// same spike stream is produced in parallel, independent of en.
// Ports:
//   clk        - clock, all state updates on the rising edge
//   rst        - synchronous active-high reset, overrides every input
//   spike      - spike from an upstream neuron, sampled every cycle
//   en         - enables rate measurement
//   rate_data  - spike count of the last completed window
//   rate_valid - rate_data holds an unconsumed result
//   rate_ready - consumer accepts rate_data
//   overrun    - sticky, a completed window result was discarded
//   trace      - decaying synaptic current for a downstream neuron
module spike_rate_decoder
  import snn_pkg::*;
#(
  parameter int         WINDOW = 64,
  parameter logic [7:0] WEIGHT = 8'd50
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       spike,
  input  logic       en,
  output logic [7:0] rate_data,
  output logic       rate_valid,
  input  logic       rate_ready,
  output logic       overrun,
  output logic [7:0] trace
);

  localparam int            CW         = $clog2(WINDOW);
  localparam logic [CW-1:0] LAST_CYCLE = CW'(WINDOW - 1);

  ctrl_state_t   state;
  ctrl_state_t   state_next;
  logic          win_active;
  logic          win_close;
  logic          transfer;
  logic [CW-1:0] win_cnt;
  logic [7:0]    spike_cnt;
  logic [7:0]    win_result;

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next state and window activity. Counters are held at zero whenever
  // no window is active, so the cycle in which en is first seen from IDLE
  // is already the first cycle of a fresh window. Dropping en in RUN
  // makes the cycle inactive, which throws the partial window away.
  always_comb begin
    state_next = state;
    win_active = 1'b0;
    case (state)
      IDLE: begin
        if (en) begin
          state_next = RUN;
          win_active = 1'b1;
        end
      end
      RUN: begin
        if (en) begin
          win_active = 1'b1;
        end else begin
          state_next = IDLE;
        end
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // The closing cycle's own spike is folded into the reported count
  assign win_close  = win_active && (win_cnt == LAST_CYCLE);
  assign win_result = sat8({1'b0, spike_cnt} + {8'd0, spike});
  assign transfer   = rate_valid && rate_ready;

  // Window and spike counters restart immediately after a close, no gap
  always_ff @(posedge clk) begin
    if (rst) begin
      win_cnt   <= '0;
      spike_cnt <= '0;
    end else if (!win_active || win_close) begin
      win_cnt   <= '0;
      spike_cnt <= '0;
    end else begin
      win_cnt   <= win_cnt + CW'(1);
      spike_cnt <= win_result;
    end
  end

  // Result register and handshake. A new result loads when the slot is
  // empty or being emptied this very cycle; otherwise it is discarded and
  // overrun latches until reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      rate_data  <= '0;
      rate_valid <= 1'b0;
      overrun    <= 1'b0;
    end else begin
      if (win_close && (!rate_valid || rate_ready)) begin
        rate_data  <= win_result;
        rate_valid <= 1'b1;
      end else begin
        if (transfer) begin
          rate_valid <= 1'b0;
        end
        if (win_close) begin
          overrun <= 1'b1;
        end
      end
    end
  end

  syn_trace #(
    .WEIGHT(WEIGHT)
  ) u_trace (
    .clk  (clk),
    .rst  (rst),
    .spike(spike),
    .trace(trace)
  );

endmodule
